// File: rtl/mux_demux_pkg.sv
// Shared types and defaults for the TDM mux/demux link.
package mux_demux_pkg;
   localparam int unsigned N_SLOTS_DEF = 8;
   typedef logic [2:0] sel_t;
   typedef logic [7:0] frame_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter; sync forces the next slot to 1 because the sync bit itself occupies slot 0.
module tdm_slot_counter #(
   parameter int unsigned N_SLOTS = 8,
   localparam int unsigned SEL_W = $clog2(N_SLOTS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc,
   input  logic             load1,
   output logic [SEL_W-1:0] slot,
   output logic             last
);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         slot <= '0;
      end else if (load1) begin
         slot <= SEL_W'(1);
      end else if (inc) begin
         slot <= slot + SEL_W'(1);
      end
   end

   assign last = (slot == SEL_W'(N_SLOTS - 1));

endmodule

// File: rtl/tdm_demux_1_to_8.sv
// Receive side of the 8:1 TDM link: assembles serial bits into frames behind a
// 1-deep valid/ready output register.
module tdm_demux_1_to_8
   import mux_demux_pkg::*;
#(
   parameter int unsigned N_SLOTS = N_SLOTS_DEF,
   localparam int unsigned SEL_W = $clog2(N_SLOTS)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               bit_i,
   input  logic               bit_valid_i,
   input  logic               sync_i,
   output logic [N_SLOTS-1:0] d_o,
   output logic               d_valid_o,
   input  logic               d_ready_i,
   output logic [SEL_W-1:0]   slot_o,
   output logic               overrun_o,
   output logic               sync_err_o
);

   logic [N_SLOTS-1:0] asm_q;
   logic [SEL_W-1:0]   slot;
   logic               last;
   logic               load1;
   logic               out_free;

   assign load1    = sync_i & bit_valid_i;
   assign out_free = ~d_valid_o | d_ready_i;
   assign slot_o   = slot;

   tdm_slot_counter #(
      .N_SLOTS(N_SLOTS)
   ) u_slot_counter (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc   (bit_valid_i),
      .load1 (load1),
      .slot  (slot),
      .last  (last)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         asm_q      <= '0;
         d_o        <= '0;
         d_valid_o  <= 1'b0;
         overrun_o  <= 1'b0;
         sync_err_o <= 1'b0;
      end else begin
         overrun_o  <= 1'b0;
         sync_err_o <= 1'b0;
         if (d_valid_o && d_ready_i) begin
            d_valid_o <= 1'b0;
         end
         if (bit_valid_i) begin
            if (sync_i) begin
               // Sync wins over completion, so a sync on the last slot never emits a frame.
               asm_q      <= '0;
               asm_q[0]   <= bit_i;
               sync_err_o <= (slot != '0);
            end else begin
               asm_q[slot] <= bit_i;
               if (last) begin
                  if (out_free) begin
                     d_o       <= {bit_i, asm_q[N_SLOTS-2:0]};
                     d_valid_o <= 1'b1;
                  end else begin
                     overrun_o <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux_1_to_8.sv
// Directed scenarios plus randomized traffic, checked against a bit-position model.
module tb_tdm_demux_1_to_8;
   import mux_demux_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       bit_i = 1'b0;
   logic       bit_valid_i = 1'b0;
   logic       sync_i = 1'b0;
   logic       d_ready_i = 1'b0;
   frame_t     d_o;
   logic       d_valid_o;
   sel_t       slot_o;
   logic       overrun_o;
   logic       sync_err_o;

   int unsigned compared = 0;
   int unsigned mism = 0;

   // reference model state
   int     m_pos = 0;
   frame_t m_part = '0;
   frame_t m_d = '0;
   logic   m_v = 1'b0;
   logic   m_ov = 1'b0;
   logic   m_se = 1'b0;

   always #5 clk_i = ~clk_i;

   tdm_demux_1_to_8 #(
      .N_SLOTS(8)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .bit_i      (bit_i),
      .bit_valid_i(bit_valid_i),
      .sync_i     (sync_i),
      .d_o        (d_o),
      .d_valid_o  (d_valid_o),
      .d_ready_i  (d_ready_i),
      .slot_o     (slot_o),
      .overrun_o  (overrun_o),
      .sync_err_o (sync_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mism++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rn, input logic b, input logic v, input logic s, input logic r);
      logic hs;
      logic done;
      rst_ni      = rn;
      bit_i       = b;
      bit_valid_i = v;
      sync_i      = s;
      d_ready_i   = r;
      done = 1'b0;
      if (!rn) begin
         m_pos = 0; m_part = '0; m_d = '0; m_v = 1'b0; m_ov = 1'b0; m_se = 1'b0;
      end else begin
         m_ov = 1'b0;
         m_se = 1'b0;
         hs = m_v && r;
         if (v) begin
            if (s) begin
               m_se   = (m_pos != 0);
               m_part = frame_t'(b);
               m_pos  = 1;
            end else begin
               m_part = m_part | (frame_t'(b) << m_pos);
               if (m_pos == 7) begin
                  done  = 1'b1;
                  m_pos = 0;
               end else begin
                  m_pos = m_pos + 1;
               end
            end
         end
         if (hs) m_v = 1'b0;
         if (done) begin
            if (!m_v) begin
               m_d = m_part;
               m_v = 1'b1;
            end else begin
               m_ov = 1'b1;
            end
            m_part = '0;
         end
      end
      @(posedge clk_i);
      #1;
      chk("d_valid", 32'(d_valid_o), 32'(m_v));
      chk("d_o", 32'(d_o), 32'(m_d));
      chk("slot", 32'(slot_o), 32'(m_pos));
      chk("overrun", 32'(overrun_o), 32'(m_ov));
      chk("sync_err", 32'(sync_err_o), 32'(m_se));
   endtask

   // bits 0..6 use ready r, last bit uses r_last; gaps inserts an idle cycle after each bit but the last
   task automatic send_frame(input frame_t f, input logic sync0, input logic r, input logic r_last,
                             input logic gaps);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, f[k], 1'b1, sync0 && (k == 0), (k == 7) ? r_last : r);
         if (gaps && k < 7) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, r);
            chk("gap_slot_hold", 32'(slot_o), 32'(k + 1));
         end
      end
   endtask

   initial begin
      frame_t f;
      // reset
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst_d_o", 32'(d_o), 32'h0);
      chk("rst_valid", 32'(d_valid_o), 32'h0);

      // 1: back-to-back frame 0x4D, valid one cycle after last bit
      send_frame(8'h4D, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t1_valid", 32'(d_valid_o), 32'h1);
      chk("t1_frame", 32'(d_o), 32'h4D);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t1_drain", 32'(d_valid_o), 32'h0);

      // 2: same frame with gaps
      send_frame(8'h4D, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("t2_frame", 32'(d_o), 32'h4D);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // 3: output stalled, second frame overruns
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_first", 32'(d_o), 32'hA5);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_overrun", 32'(overrun_o), 32'h1);
      chk("t3_hold", 32'(d_o), 32'hA5);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t3_ov_pulse", 32'(overrun_o), 32'h0);
      chk("t3_fall", 32'(d_valid_o), 32'h0);

      // 4: 5 bits, mid-frame sync, then rest of 0xFF
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t4_sync_err", 32'(sync_err_o), 32'h1);
      for (int k = 1; k < 8; k++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         chk("t4_no_partial", 32'(d_valid_o), 32'(k == 7));
      end
      chk("t4_frame", 32'(d_o), 32'hFF);

      // 5: new frame loads on the handshake edge
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t5_valid", 32'(d_valid_o), 32'h1);
      chk("t5_frame", 32'(d_o), 32'h5A);
      chk("t5_no_ov", 32'(overrun_o), 32'h0);

      // 6: reset mid-frame with a pending output
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, k == 0, 1'b0);
      chk("t6_slot4", 32'(slot_o), 32'h4);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6_d_o", 32'(d_o), 32'h0);
      chk("t6_valid", 32'(d_valid_o), 32'h0);
      chk("t6_slot", 32'(slot_o), 32'h0);
      send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t6_frame", 32'(d_o), 32'hC3);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 199) != 0,
              1'($urandom),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 11) == 0,
              1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule
